bit_scan_controller: RTL and testbench

BIT_SCAN_CONTROLLER -- requirements
Module: bit_scan_controller

---
 rtl/bit_scan_controller.sv | 147 ++++++++++++++
 tb/tb_bit_scan_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_scan_controller.sv
// -----------------------------------------------------------------------------
// bit_scan_controller
//
// Walks an external bit selector across a NrOfInputBits-wide word, one bit per
// clock. It counts the ones, remembers the lowest index holding a one, and
// flags "any one seen" and "every bit set". The scanned word itself lives
// outside the block. Its driver must keep the word stable while Busy is high.
//
// Parameters
//   NrOfInputBits : width of the scanned word (board row width)
//   NrOfSelBits   : width of the select index, 2**NrOfSelBits >= NrOfInputBits
//
// Ports
//   Clock     in   rising-edge clock
//   nReset    in   asynchronous active-low reset
//   Start     in   begin a scan (only looked at while idle)
//   Abort     in   cancel a scan in progress
//   SelBit    in   selected bit returned for the current Sel
//   Sel       out  select index driven to the external bit selector
//   Busy      out  high while scanning
//   Done      out  one-cycle pulse when a scan completes
//   OnesCount out  number of ones found
//   FirstIdx  out  lowest index holding a one
//   FoundAny  out  at least one bit was one
//   RowFull   out  every bit was one
// -----------------------------------------------------------------------------
module bit_scan_controller #(
  parameter int NrOfInputBits = 10,
  parameter int NrOfSelBits   = 4
) (
  input  logic                   Clock,
  input  logic                   nReset,
  input  logic                   Start,
  input  logic                   Abort,
  input  logic                   SelBit,
  output logic [NrOfSelBits-1:0] Sel,
  output logic                   Busy,
  output logic                   Done,
  output logic [NrOfSelBits:0]   OnesCount,
  output logic [NrOfSelBits-1:0] FirstIdx,
  output logic                   FoundAny,
  output logic                   RowFull
);

  localparam logic [NrOfSelBits-1:0] LastSel   = NrOfSelBits'(NrOfInputBits - 1);
  localparam logic [NrOfSelBits:0]   FullCount = (NrOfSelBits + 1)'(NrOfInputBits);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [NrOfSelBits-1:0] r_sel, w_sel_nxt;
  logic [NrOfSelBits:0]   r_ones, w_ones_nxt;
  logic [NrOfSelBits-1:0] r_first, w_first_nxt;
  logic                   r_found, w_found_nxt;
  logic                   r_full, w_full_nxt;

  // State and result registers
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ones  <= '0;
      r_first <= '0;
      r_found <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ones  <= w_ones_nxt;
      r_first <= w_first_nxt;
      r_found <= w_found_nxt;
      r_full  <= w_full_nxt;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ones_nxt  = r_ones;
    w_first_nxt = r_first;
    w_found_nxt = r_found;
    w_full_nxt  = r_full;

    case (r_state)
      IDLE: begin
        // Results from the previous scan stay visible until the next Start.
        if (Start) begin
          w_state_nxt = SCAN;
          w_sel_nxt   = '0;
          w_ones_nxt  = '0;
          w_first_nxt = '0;
          w_found_nxt = 1'b0;
          w_full_nxt  = 1'b0;
        end
      end

      SCAN: begin
        if (Abort) begin
          w_state_nxt = IDLE;
          w_sel_nxt   = '0;
          w_ones_nxt  = '0;
          w_first_nxt = '0;
          w_found_nxt = 1'b0;
          w_full_nxt  = 1'b0;
        end else begin
          if (SelBit) begin
            w_ones_nxt = r_ones + 1'b1;
            if (!r_found) begin
              w_first_nxt = r_sel;
              w_found_nxt = 1'b1;
            end
          end
          if (r_sel == LastSel) begin
            // Sel parks on the last index; RowFull compares against the
            // count that already includes this final bit.
            w_state_nxt = DONE;
            w_full_nxt  = (w_ones_nxt == FullCount);
          end else begin
            w_sel_nxt = r_sel + 1'b1;
          end
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign Sel       = r_sel;
  assign Busy      = (r_state == SCAN);
  assign Done      = (r_state == DONE);
  assign OnesCount = r_ones;
  assign FirstIdx  = r_first;
  assign FoundAny  = r_found;
  assign RowFull   = r_full;

endmodule

// File: tb/tb_bit_scan_controller.sv
module tb_bit_scan_controller;

  logic       Clock;
  logic       nReset;
  logic       Start;
  logic       Abort;
  logic       SelBit;
  logic [3:0] Sel;
  logic       Busy;
  logic       Done;
  logic [4:0] OnesCount;
  logic [3:0] FirstIdx;
  logic       FoundAny;
  logic       RowFull;

  logic [9:0] word;

  int checks = 0;
  int errors = 0;

  bit_scan_controller #(
    .NrOfInputBits(10),
    .NrOfSelBits  (4)
  ) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .Start    (Start),
    .Abort    (Abort),
    .SelBit   (SelBit),
    .Sel      (Sel),
    .Busy     (Busy),
    .Done     (Done),
    .OnesCount(OnesCount),
    .FirstIdx (FirstIdx),
    .FoundAny (FoundAny),
    .RowFull  (RowFull)
  );

  // External bit selector
  assign SelBit = word[Sel];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [9:0] w;
    int         ones;
    int         first;
    int         found;
    int         full;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_results(input string tag, input int ones, input int first,
                             input int found, input int full);
    chk({tag, " OnesCount"}, int'(OnesCount), ones);
    chk({tag, " FirstIdx"},  int'(FirstIdx),  first);
    chk({tag, " FoundAny"},  int'(FoundAny),  found);
    chk({tag, " RowFull"},   int'(RowFull),   full);
  endtask

  // Full scan of one word. Called and returns at a falling edge.
  task automatic run_scan(input vec_t v, input bit hold_start, input bit abort_in_done);
    word  = v.w;
    Start = 1'b1;
    @(negedge Clock);                       // start edge has passed
    if (!hold_start) Start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("scan Sel step %0d", i), int'(Sel), i);
      chk($sformatf("scan Busy step %0d", i), int'(Busy), 1);
      chk($sformatf("scan Done step %0d", i), int'(Done), 0);
      @(negedge Clock);
    end
    chk("done Done", int'(Done), 1);
    chk("done Busy", int'(Busy), 0);
    chk("done Sel held", int'(Sel), 9);
    chk_results("done", v.ones, v.first, v.found, v.full);
    if (abort_in_done) Abort = 1'b1;
    @(negedge Clock);                       // back in idle
    Abort = 1'b0;
    chk("idle Done pulse width", int'(Done), 0);
    chk("idle Busy", int'(Busy), 0);
    chk_results("idle hold", v.ones, v.first, v.found, v.full);
    Start = 1'b0;
    @(negedge Clock);
    chk("idle no restart Busy", int'(Busy), 0);
    chk("idle no restart Done", int'(Done), 0);
  endtask

  initial begin
    vecs[0] = '{10'b0000010100,  2, 2, 1, 0};
    vecs[1] = '{10'b1111111111, 10, 0, 1, 1};
    vecs[2] = '{10'b0000000000,  0, 0, 0, 0};
    vecs[3] = '{10'b1000000000,  1, 9, 1, 0};
    vecs[4] = '{10'b0000000001,  1, 0, 1, 0};
    vecs[5] = '{10'b1010101010,  5, 1, 1, 0};
    vecs[6] = '{10'b0111111111,  9, 0, 1, 0};

    word   = '0;
    Start  = 1'b0;
    Abort  = 1'b0;
    nReset = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    chk("reset Sel", int'(Sel), 0);
    chk("reset Busy", int'(Busy), 0);
    chk("reset Done", int'(Done), 0);
    chk_results("reset", 0, 0, 0, 0);
    nReset = 1'b1;
    @(negedge Clock);
    chk("post reset idle Busy", int'(Busy), 0);

    // Table-driven scans
    for (int k = 0; k < 7; k++) run_scan(vecs[k], 1'b0, 1'b0);

    // Start held high through the whole scan: exactly one scan
    run_scan(vecs[0], 1'b1, 1'b0);

    // Abort during DONE is ignored (results not cleared)
    run_scan(vecs[5], 1'b0, 1'b1);

    // Abort alone in IDLE is ignored
    Abort = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    Abort = 1'b0;
    chk("idle abort Busy", int'(Busy), 0);
    chk_results("idle abort hold", 5, 1, 1, 0);

    // Abort at Sel=5
    word  = 10'b1111111111;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge Clock);
    chk("pre-abort Sel", int'(Sel), 5);
    chk("pre-abort OnesCount", int'(OnesCount), 5);
    Abort = 1'b1;
    @(negedge Clock);
    Abort = 1'b0;
    chk("abort Busy", int'(Busy), 0);
    chk("abort Done", int'(Done), 0);
    chk("abort Sel", int'(Sel), 0);
    chk_results("abort", 0, 0, 0, 0);
    begin
      int seen_done = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge Clock);
        if (Done) seen_done++;
      end
      chk("abort no Done pulse", seen_done, 0);
      chk("abort stays idle", int'(Busy), 0);
    end

    // Start and Abort together in IDLE starts a scan
    word  = 10'b0000010100;
    Start = 1'b1;
    Abort = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    Abort = 1'b0;
    chk("start+abort Busy", int'(Busy), 1);
    begin
      int n = 0;
      while (!Done && n < 20) begin
        @(negedge Clock);
        n++;
      end
      chk("start+abort Done seen", int'(Done), 1);
      chk("start+abort latency", n, 10);
      chk_results("start+abort", 2, 2, 1, 0);
    end
    @(negedge Clock);

    // Asynchronous reset at Sel=3
    word  = 10'b1111111111;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge Clock);
    chk("pre-reset Sel", int'(Sel), 3);
    chk("pre-reset OnesCount", int'(OnesCount), 3);
    #1 nReset = 1'b0;
    #1;
    chk("async reset Sel", int'(Sel), 0);
    chk("async reset Busy", int'(Busy), 0);
    chk("async reset Done", int'(Done), 0);
    chk_results("async reset", 0, 0, 0, 0);
    @(negedge Clock);
    nReset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      chk($sformatf("post reset idle Busy %0d", i), int'(Busy), 0);
    end
    chk("post reset idle Sel", int'(Sel), 0);

    // A clean scan still works after that
    run_scan(vecs[1], 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
